// File: rtl/hci_copy_fault_ctrl_pkg.sv
// Shared types and helpers for the HCI copy-sink fault controller.
//   hci_fault_ctrl_state_e : named view of the controller FSM encoding
//   ST_*                   : FSM state constants used by the RTL
//   ptr_width()            : width of a sink index (never below 1)
package hci_copy_fault_ctrl_pkg;

  typedef enum logic [1:0] {
    FC_IDLE   = 2'd0,
    FC_WAIT   = 2'd1,
    FC_INJECT = 2'd2,
    FC_CHECK  = 2'd3
  } hci_fault_ctrl_state_e;

  localparam logic [1:0] ST_IDLE   = FC_IDLE;
  localparam logic [1:0] ST_WAIT   = FC_WAIT;
  localparam logic [1:0] ST_INJECT = FC_INJECT;
  localparam logic [1:0] ST_CHECK  = FC_CHECK;

  // A single sink still needs a 1-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hci_copy_fault_ctrl_if.sv
// Bundle of the fault controller's sink-facing and status signals.
//   master : the controller (drives inject/status/counter/pointer/irq)
//   slave  : the environment (drives fault flags, test enable, clear)
interface hci_copy_fault_ctrl_if
  import hci_copy_fault_ctrl_pkg::*;
#(
  parameter int unsigned N_SINK = 4,
  parameter int unsigned CNT_W  = 8
);
  localparam int unsigned PTR_W = ptr_width(N_SINK);

  logic [N_SINK-1:0] fault_i;
  logic              test_en_i;
  logic              clear_i;
  logic [N_SINK-1:0] inject_o;
  logic [N_SINK-1:0] fault_status_o;
  logic [N_SINK-1:0] checker_dead_o;
  logic [CNT_W-1:0]  fault_cnt_o;
  logic [PTR_W-1:0]  test_ptr_o;
  logic              irq_o;

  modport master (
    input  fault_i, test_en_i, clear_i,
    output inject_o, fault_status_o, checker_dead_o, fault_cnt_o, test_ptr_o, irq_o
  );

  modport slave (
    output fault_i, test_en_i, clear_i,
    input  inject_o, fault_status_o, checker_dead_o, fault_cnt_o, test_ptr_o, irq_o
  );

endinterface

// File: rtl/hci_copy_fault_ctrl_sat_counter.sv
// hci_sat_counter: saturating up-counter with synchronous clear.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : zero the count (an increment in the same cycle still counts)
//   inc_i        : add one, holding at all-ones
//   cnt_o        : registered count
module hci_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  // Clear first, then a same-cycle increment restarts the count at 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= WIDTH'(inc_i);
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hci_copy_fault_ctrl.sv
// hci_copy_fault_ctrl: fault manager for N_SINK lockstep copy-sink checkers.
// Collects sticky per-sink fault status, a saturating fault-cycle counter and
// an interrupt, and runs a round-robin self-test that injects a one-cycle
// mismatch into one copy stream and expects that sink's checker to flag it.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (master) : fault_i / test_en_i / clear_i in;
//                  inject_o, fault_status_o, checker_dead_o, fault_cnt_o,
//                  test_ptr_o, irq_o out (all registered)
module hci_copy_fault_ctrl
  import hci_copy_fault_ctrl_pkg::*;
#(
  parameter int unsigned N_SINK      = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TEST_PERIOD = 1024,
  parameter int unsigned INJ_LAT     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  hci_copy_fault_ctrl_if.master bus
);

  localparam int unsigned PTR_W = ptr_width(N_SINK);
  localparam int unsigned PER_W = $clog2(TEST_PERIOD);
  localparam int unsigned LAT_W = (INJ_LAT > 1) ? $clog2(INJ_LAT) : 1;

  logic [1:0]        state_q, state_d;
  logic [PER_W-1:0]  per_q, per_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [N_SINK-1:0] inject_q, inject_d;
  logic [N_SINK-1:0] status_q, status_d;
  logic [N_SINK-1:0] dead_q, dead_d;
  logic              irq_q;
  logic              check_c;
  logic [N_SINK-1:0] mask_c;
  logic [N_SINK-1:0] real_c;
  logic [N_SINK-1:0] dead_set_c;
  logic              any_real_c;
  logic [CNT_W-1:0]  fault_cnt;

  // Self-test sequencer: wait a period, inject on ptr, check on the expected cycle.
  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    lat_d    = lat_q;
    ptr_d    = ptr_q;
    inject_d = '0;
    check_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.test_en_i) begin
          per_d   = PER_W'(TEST_PERIOD - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.test_en_i) begin
          state_d = ST_IDLE;
        end else if (per_q == '0) begin
          inject_d = N_SINK'(1) << ptr_q;
          state_d  = ST_INJECT;
        end else begin
          per_d = per_q - PER_W'(1);
        end
      end
      ST_INJECT: begin
        lat_d   = LAT_W'(INJ_LAT - 1);
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        // A disable seen here only takes effect once the check has completed.
        if (lat_q == '0) begin
          check_c = 1'b1;
          ptr_d   = (ptr_q == PTR_W'(N_SINK - 1)) ? '0 : ptr_q + PTR_W'(1);
          per_d   = PER_W'(TEST_PERIOD - 1);
          state_d = bus.test_en_i ? ST_WAIT : ST_IDLE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only the targeted sink on the expected cycle is masked; everything else is real.
  always_comb begin
    mask_c     = check_c ? (N_SINK'(1) << ptr_q) : '0;
    real_c     = bus.fault_i & ~mask_c;
    dead_set_c = (check_c && !bus.fault_i[ptr_q]) ? mask_c : '0;
    any_real_c = |real_c;
    status_d   = (bus.clear_i ? '0 : status_q) | real_c;
    dead_d     = (bus.clear_i ? '0 : dead_q) | dead_set_c;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      per_q    <= '0;
      lat_q    <= '0;
      ptr_q    <= '0;
      inject_q <= '0;
      status_q <= '0;
      dead_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      lat_q    <= lat_d;
      ptr_q    <= ptr_d;
      inject_q <= inject_d;
      status_q <= status_d;
      dead_q   <= dead_d;
      irq_q    <= (|status_q) | (|dead_q);
    end
  end

  hci_sat_counter #(
    .WIDTH (CNT_W)
  ) u_fault_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (bus.clear_i),
    .inc_i   (any_real_c),
    .cnt_o   (fault_cnt)
  );

  assign bus.inject_o       = inject_q;
  assign bus.fault_status_o = status_q;
  assign bus.checker_dead_o = dead_q;
  assign bus.fault_cnt_o    = fault_cnt;
  assign bus.test_ptr_o     = ptr_q;
  assign bus.irq_o          = irq_q;

endmodule

// File: tb/tb_hci_copy_fault_ctrl.sv
// Scoreboard bench: expectations are queued with a due cycle when stimulus is
// driven and compared when that cycle's outputs are sampled on the falling edge.
// dut_a: defaults with a short period; dut_b: 2-bit counter, INJ_LAT=2.
module tb_hci_copy_fault_ctrl;

  localparam int F_A_STAT = 0, F_A_DEAD = 1, F_A_CNT = 2, F_A_IRQ = 3, F_A_PTR = 4, F_A_INJ = 5;
  localparam int F_B_STAT = 6, F_B_DEAD = 7, F_B_CNT = 8, F_B_IRQ = 9, F_B_PTR = 10;

  typedef struct {
    int          due;
    int          sel;
    string       tag;
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    int         due;
    logic [3:0] val;
  } inj_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  exp_t sb_q[$];
  inj_t inj_q_a[$];
  inj_t inj_q_b[$];

  logic [3:0] real_a = '0, real_b = '0;
  logic [3:0] echo_a = '0, echo_b = '0;
  logic [3:0] silent_a = 4'b0100;
  logic [3:0] early_b  = 4'b0010;
  logic [3:0] ha0 = '0, hb0 = '0, hb1 = '0;

  hci_copy_fault_ctrl_if #(.N_SINK(4), .CNT_W(8)) bus_a ();
  hci_copy_fault_ctrl_if #(.N_SINK(4), .CNT_W(2)) bus_b ();

  hci_copy_fault_ctrl #(.N_SINK(4), .CNT_W(8), .TEST_PERIOD(8), .INJ_LAT(1)) dut_a (
    .clk_i (clk), .rst_i (rst_a), .bus (bus_a.master)
  );
  hci_copy_fault_ctrl #(.N_SINK(4), .CNT_W(2), .TEST_PERIOD(8), .INJ_LAT(2)) dut_b (
    .clk_i (clk), .rst_i (rst_b), .bus (bus_b.master)
  );

  assign bus_a.fault_i = echo_a | real_a;
  assign bus_b.fault_i = echo_b | real_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic expect_at(input int dly, input int sel, input string tag, input logic [31:0] exp);
    exp_t e;
    e.due = cyc + dly; e.sel = sel; e.tag = tag; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic push_inj_a(input int dly, input logic [3:0] v);
    inj_t e;
    e.due = cyc + dly; e.val = v;
    inj_q_a.push_back(e);
  endtask

  task automatic push_inj_b(input int dly, input logic [3:0] v);
    inj_t e;
    e.due = cyc + dly; e.val = v;
    inj_q_b.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] field(input int sel);
    case (sel)
      F_A_STAT: return 32'(bus_a.fault_status_o);
      F_A_DEAD: return 32'(bus_a.checker_dead_o);
      F_A_CNT:  return 32'(bus_a.fault_cnt_o);
      F_A_IRQ:  return 32'(bus_a.irq_o);
      F_A_PTR:  return 32'(bus_a.test_ptr_o);
      F_A_INJ:  return 32'(bus_a.inject_o);
      F_B_STAT: return 32'(bus_b.fault_status_o);
      F_B_DEAD: return 32'(bus_b.checker_dead_o);
      F_B_CNT:  return 32'(bus_b.fault_cnt_o);
      F_B_IRQ:  return 32'(bus_b.irq_o);
      F_B_PTR:  return 32'(bus_b.test_ptr_o);
      default:  return 32'hdead_beef;
    endcase
  endfunction

  // Copy-sink models: dut_a sinks echo an injection one cycle later (unless
  // silenced); dut_b sinks echo two cycles later, except "early" sinks at one.
  always @(negedge clk) begin
    echo_a = ha0 & ~silent_a;
    echo_b = (hb1 & ~early_b) | (hb0 & early_b);
    hb1    = hb0;
    hb0    = bus_b.inject_o;
    ha0    = bus_a.inject_o;
  end

  // Scoreboard drain: value checks that fall due now, plus injection events.
  always @(negedge clk) begin
    inj_t e;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        check_val(sb_q[i].tag, field(sb_q[i].sel), sb_q[i].exp);
        sb_q.delete(i);
      end
    end
    if (inj_q_a.size() > 0 && inj_q_a[0].due < cyc) begin
      e = inj_q_a.pop_front();
      check_val("a_inj_missing", 32'(0), 32'(e.val));
    end
    if (bus_a.inject_o != '0) begin
      if (inj_q_a.size() == 0) check_val("a_inj_unexpected", 32'(bus_a.inject_o), 32'(0));
      else begin
        e = inj_q_a.pop_front();
        check_val("a_inj_val", 32'(bus_a.inject_o), 32'(e.val));
        check_val("a_inj_cycle", 32'(cyc), 32'(e.due));
      end
    end
    if (inj_q_b.size() > 0 && inj_q_b[0].due < cyc) begin
      e = inj_q_b.pop_front();
      check_val("b_inj_missing", 32'(0), 32'(e.val));
    end
    if (bus_b.inject_o != '0) begin
      if (inj_q_b.size() == 0) check_val("b_inj_unexpected", 32'(bus_b.inject_o), 32'(0));
      else begin
        e = inj_q_b.pop_front();
        check_val("b_inj_val", 32'(bus_b.inject_o), 32'(e.val));
        check_val("b_inj_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.test_en_i = 1'b0; bus_a.clear_i = 1'b0;
    bus_b.test_en_i = 1'b0; bus_b.clear_i = 1'b0;
    step(3);
    rst_a = 1'b0; rst_b = 1'b0;
    expect_at(1, F_A_STAT, "rst_a_stat", 0);
    expect_at(1, F_A_DEAD, "rst_a_dead", 0);
    expect_at(1, F_A_CNT,  "rst_a_cnt",  0);
    expect_at(1, F_A_IRQ,  "rst_a_irq",  0);
    expect_at(1, F_A_PTR,  "rst_a_ptr",  0);
    expect_at(1, F_A_INJ,  "rst_a_inj",  0);
    expect_at(1, F_B_STAT, "rst_b_stat", 0);
    expect_at(1, F_B_CNT,  "rst_b_cnt",  0);
    step(2);

    // Round-robin self-test with sink 2 silent.
    bus_a.test_en_i = 1'b1;
    push_inj_a(9,  4'b0001);
    push_inj_a(19, 4'b0010);
    push_inj_a(29, 4'b0100);
    push_inj_a(39, 4'b1000);
    expect_at(10, F_A_PTR,  "st_ptr_before", 0);
    expect_at(11, F_A_PTR,  "st_ptr_after",  1);
    expect_at(12, F_A_STAT, "st_stat_ok",    0);
    expect_at(12, F_A_CNT,  "st_cnt_ok",     0);
    expect_at(25, F_A_DEAD, "st_dead_none",  0);
    expect_at(31, F_A_DEAD, "st_dead_s2",    32'b0100);
    expect_at(31, F_A_IRQ,  "st_irq_lag",    0);
    expect_at(32, F_A_IRQ,  "st_irq_set",    1);
    step(40);

    // Disable during the CHECK of sink 3: check completes, then idle.
    bus_a.test_en_i = 1'b0;
    expect_at(1, F_A_PTR,  "dis_ptr_wrap", 0);
    expect_at(5, F_A_DEAD, "dis_dead",     32'b0100);
    expect_at(5, F_A_STAT, "dis_stat",     0);
    step(30);

    // Real fault 1010 for 3 cycles while idle, after a clear.
    bus_a.clear_i = 1'b1;
    expect_at(1, F_A_DEAD, "clr_dead", 0);
    expect_at(1, F_A_STAT, "clr_stat", 0);
    expect_at(1, F_A_CNT,  "clr_cnt",  0);
    expect_at(2, F_A_STAT, "rf_stat",  32'b1010);
    expect_at(2, F_A_CNT,  "rf_cnt1",  1);
    expect_at(2, F_A_IRQ,  "rf_irq_lag", 0);
    expect_at(3, F_A_IRQ,  "rf_irq",   1);
    expect_at(5, F_A_CNT,  "rf_cnt3",  3);
    expect_at(6, F_A_STAT, "rf_stat_hold", 32'b1010);
    step(1);
    bus_a.clear_i = 1'b0;
    real_a = 4'b1010;
    step(3);
    real_a = 4'b0000;
    step(4);

    // Reset while INJECT is active.
    silent_a = 4'b1111;
    bus_a.test_en_i = 1'b1;
    push_inj_a(9, 4'b0001);
    step(9);
    rst_a = 1'b1;
    bus_a.test_en_i = 1'b0;
    expect_at(1, F_A_INJ,  "rst_inj",  0);
    expect_at(1, F_A_STAT, "rst_stat", 0);
    expect_at(1, F_A_DEAD, "rst_dead", 0);
    expect_at(1, F_A_CNT,  "rst_cnt",  0);
    expect_at(1, F_A_IRQ,  "rst_irq",  0);
    expect_at(1, F_A_PTR,  "rst_ptr",  0);
    step(2);
    rst_a = 1'b0;
    expect_at(6, F_A_INJ,  "rst_idle_inj", 0);
    step(6);

    // Saturation with a 2-bit counter.
    real_b = 4'b0100;
    expect_at(1,  F_B_CNT,  "sat_cnt1", 1);
    expect_at(1,  F_B_STAT, "sat_stat", 32'b0100);
    expect_at(2,  F_B_CNT,  "sat_cnt2", 2);
    expect_at(3,  F_B_CNT,  "sat_cnt3", 3);
    expect_at(9,  F_B_CNT,  "sat_hold", 3);
    expect_at(11, F_B_CNT,  "sat_end",  3);
    step(10);
    real_b = 4'b0000;
    step(2);
    bus_b.clear_i = 1'b1;
    expect_at(1, F_B_CNT,  "bclr_cnt",  0);
    expect_at(1, F_B_STAT, "bclr_stat", 0);
    expect_at(1, F_B_IRQ,  "bclr_irq_lag", 1);
    expect_at(2, F_B_IRQ,  "bclr_irq",  0);
    step(1);
    bus_b.clear_i = 1'b0;
    real_b = 4'b0010;
    expect_at(1, F_B_STAT, "pre_stat", 32'b0010);
    expect_at(1, F_B_CNT,  "pre_cnt",  1);
    expect_at(2, F_B_STAT, "clrf_stat", 32'b0001);
    expect_at(2, F_B_CNT,  "clrf_cnt",  1);
    expect_at(4, F_B_STAT, "clrf_hold", 32'b0001);
    step(1);
    real_b = 4'b0001;
    bus_b.clear_i = 1'b1;
    step(1);
    real_b = 4'b0000;
    bus_b.clear_i = 1'b0;
    step(4);

    // Mask boundary: INJ_LAT=2, sink 1 answers one cycle early.
    bus_b.test_en_i = 1'b1;
    bus_b.clear_i = 1'b1;
    push_inj_b(9,  4'b0001);
    push_inj_b(20, 4'b0010);
    expect_at(21, F_B_STAT, "mb_stat_s0",  0);
    expect_at(21, F_B_DEAD, "mb_dead_s0",  0);
    expect_at(24, F_B_STAT, "mb_stat_s1",  32'b0010);
    expect_at(24, F_B_DEAD, "mb_dead_s1",  32'b0010);
    expect_at(24, F_B_CNT,  "mb_cnt",      1);
    expect_at(24, F_B_PTR,  "mb_ptr",      2);
    expect_at(24, F_B_IRQ,  "mb_irq",      1);
    step(1);
    bus_b.clear_i = 1'b0;
    step(24);
    bus_b.test_en_i = 1'b0;
    step(20);

    check_val("a_inj_left", 32'(inj_q_a.size()), 0);
    check_val("b_inj_left", 32'(inj_q_b.size()), 0);
    check_val("sb_left",    32'(sb_q.size()),    0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
